// File: rtl/bram_fifo_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : bram_fifo_tx_if
// Description : Bus and FIFO-side signal bundle for bram_fifo_tx.
//               master = bus host / downstream consumer side (testbench),
//               slave  = the FIFO block itself.
//   BUS_ADD/BUS_DATA_IN/BUS_RD/BUS_WR/BUS_DATA_OUT : 8-bit control window
//   BUS_WR_DATA/BUS_DATA_IN_DATA                   : 32-bit data push window
//   FIFO_READ_NEXT_IN/FIFO_EMPTY_OUT/FIFO_DATA_OUT : FWFT read interface
//   FIFO_FULL/FIFO_NEAR_FULL/FIFO_OVERFLOW/FIFO_READ_ERROR : status flags
// Revision    : 1.0 - initial release
// ============================================================================
interface bram_fifo_tx_if #(
   parameter int ABUSWIDTH = 32
);
   logic [ABUSWIDTH-1:0] BUS_ADD;
   logic [7:0]           BUS_DATA_IN;
   logic                 BUS_RD;
   logic                 BUS_WR;
   logic [7:0]           BUS_DATA_OUT;
   logic                 BUS_WR_DATA;
   logic [31:0]          BUS_DATA_IN_DATA;
   logic                 FIFO_READ_NEXT_IN;
   logic                 FIFO_EMPTY_OUT;
   logic [31:0]          FIFO_DATA_OUT;
   logic                 FIFO_FULL;
   logic                 FIFO_NEAR_FULL;
   logic                 FIFO_OVERFLOW;
   logic                 FIFO_READ_ERROR;

   modport master (
      output BUS_ADD, BUS_DATA_IN, BUS_RD, BUS_WR, BUS_WR_DATA, BUS_DATA_IN_DATA,
             FIFO_READ_NEXT_IN,
      input  BUS_DATA_OUT, FIFO_EMPTY_OUT, FIFO_DATA_OUT, FIFO_FULL, FIFO_NEAR_FULL,
             FIFO_OVERFLOW, FIFO_READ_ERROR
   );

   modport slave (
      input  BUS_ADD, BUS_DATA_IN, BUS_RD, BUS_WR, BUS_WR_DATA, BUS_DATA_IN_DATA,
             FIFO_READ_NEXT_IN,
      output BUS_DATA_OUT, FIFO_EMPTY_OUT, FIFO_DATA_OUT, FIFO_FULL, FIFO_NEAR_FULL,
             FIFO_OVERFLOW, FIFO_READ_ERROR
   );
endinterface
`default_nettype wire

// File: rtl/bram_fifo_tx.sv
`default_nettype none
// ============================================================================
// Module      : bram_fifo_tx
// Description : Host-to-fabric block-RAM FIFO. The bus pushes 32-bit words,
//               downstream logic pops them through a first-word-fall-through
//               interface. An 8-bit control window exposes version, enable,
//               soft reset, occupancy, status flags and a sent-word counter.
// Ports       : BUS_CLK - single clock for bus and FIFO side
//               BUS_RST - asynchronous active-high reset
//               bus     - bram_fifo_tx_if.slave (control, push, pop, flags)
// Revision    : 1.0 - initial release
// ============================================================================
module bram_fifo_tx #(
   parameter int DEPTH                       = 1024,
   parameter int ABUSWIDTH                   = 32,
   parameter int FIFO_ALMOST_FULL_THRESHOLD  = 95,
   parameter int FIFO_ALMOST_EMPTY_THRESHOLD = 5,
   parameter int VERSION                     = 1
) (
   input wire logic      BUS_CLK,
   input wire logic      BUS_RST,
   bram_fifo_tx_if.slave bus
);
   localparam int c_aw = $clog2(DEPTH);
   localparam int c_cw = c_aw + 1;

   localparam logic [c_cw-1:0] c_depth            = c_cw'(DEPTH);
   localparam logic [c_cw-1:0] c_near_full_lvl    = c_cw'(DEPTH * FIFO_ALMOST_FULL_THRESHOLD / 100);
   localparam logic [c_cw-1:0] c_almost_empty_lvl = c_cw'(DEPTH * FIFO_ALMOST_EMPTY_THRESHOLD / 100);
   localparam logic [7:0]      c_version          = 8'(VERSION);

   localparam logic [ABUSWIDTH-1:0] c_addr_version = ABUSWIDTH'(0);
   localparam logic [ABUSWIDTH-1:0] c_addr_ctrl    = ABUSWIDTH'(1);
   localparam logic [ABUSWIDTH-1:0] c_addr_occ0    = ABUSWIDTH'(2);
   localparam logic [ABUSWIDTH-1:0] c_addr_occ1    = ABUSWIDTH'(3);
   localparam logic [ABUSWIDTH-1:0] c_addr_occ2    = ABUSWIDTH'(4);
   localparam logic [ABUSWIDTH-1:0] c_addr_occ3    = ABUSWIDTH'(5);
   localparam logic [ABUSWIDTH-1:0] c_addr_status  = ABUSWIDTH'(6);
   localparam logic [ABUSWIDTH-1:0] c_addr_sent0   = ABUSWIDTH'(7);
   localparam logic [ABUSWIDTH-1:0] c_addr_sent1   = ABUSWIDTH'(8);
   localparam logic [ABUSWIDTH-1:0] c_addr_sent2   = ABUSWIDTH'(9);
   localparam logic [ABUSWIDTH-1:0] c_addr_sent3   = ABUSWIDTH'(10);

   logic [31:0]     r_mem [DEPTH];
   logic [c_aw-1:0] r_wr_ptr;
   logic [c_aw-1:0] r_rd_ptr;
   logic [c_cw-1:0] r_count;        // includes the word held in r_dout
   logic [31:0]     r_dout;
   logic            r_dout_valid;
   logic            r_enable;
   logic            r_soft_rst;
   logic            r_overflow;
   logic            r_read_error;
   logic            r_empty;
   logic            r_full;
   logic            r_near_full;
   logic            r_almost_empty;
   logic [31:0]     r_sent;
   logic [23:0]     r_count_snap;   // bytes 1..3; byte 0 is returned live
   logic [23:0]     r_sent_snap;
   logic [7:0]      r_bus_data_out;

   logic            w_full_now;
   logic            w_push;
   logic            w_pop;
   logic            w_pop_err;
   logic            w_load;
   logic            w_ovf_clr;
   logic [c_cw-1:0] w_ram_cnt;
   logic [c_cw-1:0] w_count_next;
   logic [31:0]     w_count32;
   logic [7:0]      w_rd_data;
   logic            w_unused;

   assign w_unused = &{1'b0, bus.BUS_DATA_IN[7:2]};

   // A same-cycle pop never frees a slot for a push: fullness is judged on
   // the occupancy at the start of the cycle.
   assign w_full_now = (r_count == c_depth);
   assign w_push     = bus.BUS_WR_DATA && !w_full_now && !r_soft_rst;
   assign w_pop      = bus.FIFO_READ_NEXT_IN && r_enable && r_dout_valid && !r_soft_rst;
   assign w_pop_err  = bus.FIFO_READ_NEXT_IN && r_enable && !r_dout_valid;
   assign w_ovf_clr  = bus.BUS_WR && (bus.BUS_ADD == c_addr_ctrl) && bus.BUS_DATA_IN[1];

   // Words sitting in RAM that have not yet been moved into the output
   // register. A word pushed this cycle is not counted, so the RAM is never
   // read at an address being written in the same cycle.
   assign w_ram_cnt = r_count - c_cw'(r_dout_valid);
   assign w_load    = !r_soft_rst && (w_ram_cnt != '0) && (!r_dout_valid || w_pop);

   assign w_count_next = r_soft_rst ? '0
                                    : r_count + c_cw'(w_push) - c_cw'(w_pop);
   assign w_count32    = 32'(r_count);

   always_comb begin
      w_rd_data = 8'h00;
      case (bus.BUS_ADD)
         c_addr_version : w_rd_data = c_version;
         c_addr_ctrl    : w_rd_data = {7'd0, r_enable};
         c_addr_occ0    : w_rd_data = w_count32[7:0];
         c_addr_occ1    : w_rd_data = r_count_snap[7:0];
         c_addr_occ2    : w_rd_data = r_count_snap[15:8];
         c_addr_occ3    : w_rd_data = r_count_snap[23:16];
         c_addr_status  : w_rd_data = {3'b000, r_almost_empty, r_overflow,
                                       r_near_full, r_full, r_empty};
         c_addr_sent0   : w_rd_data = r_sent[7:0];
         c_addr_sent1   : w_rd_data = r_sent_snap[7:0];
         c_addr_sent2   : w_rd_data = r_sent_snap[15:8];
         c_addr_sent3   : w_rd_data = r_sent_snap[23:16];
         default        : w_rd_data = 8'h00;
      endcase
   end

   // Storage array kept free of reset so it maps onto block RAM.
   always_ff @(posedge BUS_CLK) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.BUS_DATA_IN_DATA;
      end
   end

   always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
      if (BUS_RST) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_dout         <= '0;
         r_dout_valid   <= 1'b0;
         r_enable       <= 1'b0;
         r_soft_rst     <= 1'b0;
         r_overflow     <= 1'b0;
         r_read_error   <= 1'b0;
         r_empty        <= 1'b0;
         r_full         <= 1'b0;
         r_near_full    <= 1'b0;
         r_almost_empty <= 1'b0;
         r_sent         <= '0;
         r_count_snap   <= '0;
         r_sent_snap    <= '0;
         r_bus_data_out <= '0;
      end else begin
         // Any write to address 0 schedules a soft reset for the next cycle.
         r_soft_rst <= bus.BUS_WR && (bus.BUS_ADD == c_addr_version);
         if (bus.BUS_WR && (bus.BUS_ADD == c_addr_ctrl)) begin
            r_enable <= bus.BUS_DATA_IN[0];
         end

         if (bus.BUS_RD) begin
            r_bus_data_out <= w_rd_data;
            if (bus.BUS_ADD == c_addr_occ0) begin
               r_count_snap <= w_count32[31:8];
            end
            if (bus.BUS_ADD == c_addr_sent0) begin
               r_sent_snap <= r_sent[31:8];
            end
         end

         r_read_error <= w_pop_err;

         if (r_soft_rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_dout_valid <= 1'b0;
            r_sent       <= '0;
            r_overflow   <= 1'b0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            // Prefetch: refill the output register whenever it is empty or
            // being consumed, giving one word per cycle on back-to-back pops.
            if (w_load) begin
               r_dout       <= r_mem[r_rd_ptr];
               r_rd_ptr     <= r_rd_ptr + 1'b1;
               r_dout_valid <= 1'b1;
            end else if (w_pop) begin
               r_dout_valid <= 1'b0;
            end
            if (w_pop) begin
               r_sent <= r_sent + 32'd1;
            end
            if (w_ovf_clr) begin
               r_overflow <= 1'b0;
            end
            if (bus.BUS_WR_DATA && w_full_now) begin
               r_overflow <= 1'b1;
            end
         end

         r_count        <= w_count_next;
         r_empty        <= (w_count_next == '0);
         r_full         <= (w_count_next == c_depth);
         r_near_full    <= (w_count_next >= c_near_full_lvl);
         r_almost_empty <= (w_count_next <= c_almost_empty_lvl);
      end
   end

   assign bus.BUS_DATA_OUT    = r_bus_data_out;
   assign bus.FIFO_EMPTY_OUT  = !(r_dout_valid && r_enable);
   assign bus.FIFO_DATA_OUT   = r_dout;
   assign bus.FIFO_FULL       = r_full;
   assign bus.FIFO_NEAR_FULL  = r_near_full;
   assign bus.FIFO_OVERFLOW   = r_overflow;
   assign bus.FIFO_READ_ERROR = r_read_error;

endmodule
`default_nettype wire

// File: doc/bram_fifo_tx.md
Name: bram_fifo_tx

Overview:
Host-to-fabric counterpart of the block-RAM readout FIFO. The bus writes 32-bit words through a data address window. The block buffers them in block RAM and presents them to downstream logic on a first-word-fall-through FIFO read interface (read-next / empty / data). An 8-bit control window provides version, enable, soft reset, fill level, status flags and a sent-word counter. The block sits behind two bus_to_ip decoders, one 8-bit and one 32-bit, in the same arrangement as the readout FIFO.

Parameters:
DEPTH, 1024, storage in 32-bit words; power of two, at least 4.
ABUSWIDTH, 32, control address width.
FIFO_ALMOST_FULL_THRESHOLD, 95, near-full level in percent of DEPTH.
FIFO_ALMOST_EMPTY_THRESHOLD, 5, almost-empty level in percent of DEPTH.
VERSION, 1, value read at control address 0.

Ports:
BUS_CLK  in  1  single clock for bus and FIFO side.
BUS_RST  in  1  asynchronous, active-high reset.
BUS_ADD  in  ABUSWIDTH  control register address (IP-relative).
BUS_DATA_IN  in  8  control write data.
BUS_RD  in  1  control read strobe.
BUS_WR  in  1  control write strobe.
BUS_DATA_OUT  out  8  control read data.
BUS_WR_DATA  in  1  data-window write strobe; pushes one word.
BUS_DATA_IN_DATA  in  32  word to push.
FIFO_READ_NEXT_IN  in  1  downstream pop request.
FIFO_EMPTY_OUT  out  1  high = no valid word on FIFO_DATA_OUT.
FIFO_DATA_OUT  out  32  head word; valid while FIFO_EMPTY_OUT is low.
FIFO_FULL  out  1  occupancy equals DEPTH.
FIFO_NEAR_FULL  out  1  occupancy at or above the near-full level.
FIFO_OVERFLOW  out  1  sticky; a bus write was dropped.
FIFO_READ_ERROR  out  1  one-cycle pulse when a pop is requested while empty and enabled.

Behaviour:
- Reset (asynchronous BUS_RST):
  - Pointers, occupancy, sent counter, OVERFLOW and ENABLE are cleared.
  - FIFO_EMPTY_OUT=1, FIFO_DATA_OUT=0, BUS_DATA_OUT=0, all flags 0.
  - Reset mid-transfer discards all stored data.
- Control map (BUS_DATA_OUT is registered and valid the cycle after BUS_RD):
  - 0: read returns VERSION. Any write performs a soft reset the following cycle. Soft reset clears pointers, occupancy, sent counter and OVERFLOW; ENABLE is kept.
  - 1: bit0 ENABLE (R/W). Writing 1 to bit1 clears OVERFLOW; bit1 reads 0.
  - 2..5: occupancy, little-endian. Reading byte 2 latches all 4 bytes into a snapshot; reads of 3..5 return the snapshot.
  - 6: status. bit0 empty, bit1 full, bit2 near-full, bit3 overflow, bit4 almost-empty. Other bits read 0.
  - 7..10: sent-word counter, little-endian. Reading byte 7 snapshots it. The counter wraps at 2^32.
  - Unmapped addresses read 0; writes to them are ignored.
- Push:
  - BUS_WR_DATA while not full stores the word and increments occupancy.
  - BUS_WR_DATA while full drops the word and sets OVERFLOW.
  - Push is accepted regardless of ENABLE.
- Pop:
  - RAM read latency is 1 cycle, with a prefetch output register (FWFT). Occupancy counts the output-register word.
  - A word written into an empty FIFO gives FIFO_EMPTY_OUT=0 exactly 2 cycles after the write strobe.
  - FIFO_READ_NEXT_IN with FIFO_EMPTY_OUT=0 consumes the head word. The next word is presented the following cycle, so back-to-back pops sustain 1 word/cycle.
  - Each pop increments the sent counter.
- ENABLE=0:
  - FIFO_EMPTY_OUT is forced to 1 and pops are ignored, with no error pulse.
  - Stored data is retained.
- Simultaneous push and pop: both occur and occupancy is unchanged.
  - When full, a same-cycle pop does not make room for the push; the push is dropped and OVERFLOW is set.
- Pointer wrap: pointers are log2(DEPTH) bits wide and wrap naturally. Occupancy is log2(DEPTH)+1 bits wide.
- Thresholds:
  - Near-full: occupancy >= DEPTH*FIFO_ALMOST_FULL_THRESHOLD/100.
  - Almost-empty: occupancy <= DEPTH*FIFO_ALMOST_EMPTY_THRESHOLD/100.
  - Both use integer truncation, computed at elaboration.
- Flag timing: all flags are registered and reflect occupancy after the current cycle's push/pop.

Test Plan:
- Reset, write 1 to ctrl addr 1, push 0xA5A50001..0xA5A50004 -> FIFO_EMPTY_OUT falls 2 cycles after the first push. Popping every cycle yields the 4 words in order, then EMPTY=1. Sent counter = 4.
- Fill DEPTH=16 with 16 words, push one more -> FIFO_FULL=1, OVERFLOW=1, status byte reads 0x0E. The 17th word never appears. Writing 0x02 to addr 1 clears OVERFLOW.
- Pop while empty and enabled -> FIFO_READ_ERROR pulses for exactly 1 cycle. Same with ENABLE=0 -> no pulse and EMPTY held at 1.
- With 8 words stored, do simultaneous push and pop for 20 cycles -> occupancy at addr 2 reads 8 throughout and data order is preserved across pointer wrap.
- DEPTH=16 with 15 words stored -> NEAR_FULL=1 (level 15); with 14 words -> 0. Occupancy 0 -> almost-empty=1; occupancy 1 -> almost-empty=0.
- Assert BUS_RST with 5 words stored and a pop in flight -> outputs return to reset values immediately. A subsequent write to addr 0 with ENABLE=1 keeps ENABLE and reads occupancy 0.
